ram64_bist: RTL and testbench

RAM64_BIST -- requirements
Module: ram64_bist

---
 rtl/ram64_bist_if.sv | 30 +++
 rtl/ram64_bist.sv | 202 ++++++++++++++++++++
 tb/tb_ram64_bist.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram64_bist_if.sv
// Bus between the March BIST engine and its host / memory.
// The slave modport belongs to the BIST engine; the master modport belongs to
// whatever owns the memory and issues start requests.
interface ram64_bist_if;
    logic        start;
    logic [15:0] pat;
    logic [5:0]  mem_add;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [15:0] mem_o;
    logic        busy;
    logic        done;
    logic        fail;
    logic [5:0]  fail_add;
    logic [15:0] fail_exp;
    logic [15:0] fail_act;
    logic [6:0]  err_cnt;

    modport slave (
        input  start, pat, mem_o,
        output mem_add, mem_in, mem_load, busy, done,
               fail, fail_add, fail_exp, fail_act, err_cnt
    );

    modport master (
        output start, pat, mem_o,
        input  mem_add, mem_in, mem_load, busy, done,
               fail, fail_add, fail_exp, fail_act, err_cnt
    );
endinterface

// File: rtl/ram64_bist.sv
// March BIST engine for a 64x16 single-port memory.
// Sequence: M0 up(wP), M1 up(rP,w~P), M2 down(r~P,wP), M3 down(rP).
// All memory-side outputs are registered and computed from the next state,
// so in a read cycle mem_in already carries the value the read is checked against.
module ram64_bist #(
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    ram64_bist_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        M0_W = 4'd1,
        M1_R = 4'd2,
        M1_W = 4'd3,
        M2_R = 4'd4,
        M2_W = 4'd5,
        M3_R = 4'd6,
        DONE = 4'd7
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [5:0]  addr_r;
    logic [5:0]  next_addr_s;
    logic [15:0] pat_r;
    logic [15:0] next_pat_s;
    logic [15:0] mem_in_r;
    logic        mem_load_r;
    logic        busy_r;
    logic        done_r;
    logic        fail_r;
    logic [5:0]  fail_add_r;
    logic [15:0] fail_exp_r;
    logic [15:0] fail_act_r;
    logic [6:0]  err_cnt_r;
    logic        accept_s;
    logic        mismatch_s;
    logic        stop_s;

    // Value driven on mem_in for a given state: write data or expected read data.
    function automatic logic [15:0] data_for(input state_t s, input logic [15:0] p);
        case (s)
            M0_W, M1_R, M2_W, M3_R: data_for = p;
            M1_W, M2_R:             data_for = ~p;
            default:                data_for = 16'h0000;
        endcase
    endfunction

    function automatic logic is_read(input state_t s);
        case (s)
            M1_R, M2_R, M3_R: is_read = 1'b1;
            default:          is_read = 1'b0;
        endcase
    endfunction

    function automatic logic is_write(input state_t s);
        case (s)
            M0_W, M1_W, M2_W: is_write = 1'b1;
            default:          is_write = 1'b0;
        endcase
    endfunction

    function automatic logic is_busy(input state_t s);
        case (s)
            M0_W, M1_R, M1_W, M2_R, M2_W, M3_R: is_busy = 1'b1;
            default:                            is_busy = 1'b0;
        endcase
    endfunction

    // Next-state, address and read-compare decode for the March sequence.
    always_comb begin
        accept_s     = 1'b0;
        next_state_s = state_r;
        next_addr_s  = addr_r;
        next_pat_s   = pat_r;
        if (is_read(state_r)) begin
            mismatch_s = (bus.mem_o != mem_in_r);
        end else begin
            mismatch_s = 1'b0;
        end
        stop_s = mismatch_s && STOP_ON_FAIL;
        case (state_r)
            IDLE, DONE: begin
                next_addr_s = 6'd0;
                if (bus.start) begin
                    accept_s     = 1'b1;
                    next_state_s = M0_W;
                    next_pat_s   = bus.pat;
                end else begin
                    next_state_s = state_r;
                end
            end
            M0_W: begin
                if (addr_r == 6'd63) begin
                    next_state_s = M1_R;
                    next_addr_s  = 6'd0;
                end else begin
                    next_addr_s  = addr_r + 6'd1;
                end
            end
            M1_R, M2_R: begin
                if (stop_s) begin
                    next_state_s = DONE;
                    next_addr_s  = 6'd0;
                end else begin
                    next_state_s = (state_r == M1_R) ? M1_W : M2_W;
                end
            end
            M1_W: begin
                if (addr_r == 6'd63) begin
                    next_state_s = M2_R;
                end else begin
                    next_state_s = M1_R;
                    next_addr_s  = addr_r + 6'd1;
                end
            end
            M2_W: begin
                if (addr_r == 6'd0) begin
                    next_state_s = M3_R;
                    next_addr_s  = 6'd63;
                end else begin
                    next_state_s = M2_R;
                    next_addr_s  = addr_r - 6'd1;
                end
            end
            M3_R: begin
                if (stop_s || (addr_r == 6'd0)) begin
                    next_state_s = DONE;
                    next_addr_s  = 6'd0;
                end else begin
                    next_addr_s  = addr_r - 6'd1;
                end
            end
            default: begin
                next_state_s = IDLE;
                next_addr_s  = 6'd0;
            end
        endcase
    end

    // State, registered memory-side outputs and first-failure capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            addr_r     <= 6'd0;
            pat_r      <= 16'h0000;
            mem_in_r   <= 16'h0000;
            mem_load_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            fail_r     <= 1'b0;
            fail_add_r <= 6'd0;
            fail_exp_r <= 16'h0000;
            fail_act_r <= 16'h0000;
            err_cnt_r  <= 7'd0;
        end else begin
            state_r    <= next_state_s;
            addr_r     <= next_addr_s;
            pat_r      <= next_pat_s;
            mem_in_r   <= data_for(next_state_s, next_pat_s);
            mem_load_r <= is_write(next_state_s);
            busy_r     <= is_busy(next_state_s);
            if (accept_s) begin
                done_r     <= 1'b0;
                fail_r     <= 1'b0;
                fail_add_r <= 6'd0;
                fail_exp_r <= 16'h0000;
                fail_act_r <= 16'h0000;
                err_cnt_r  <= 7'd0;
            end else begin
                // done trails entry into DONE by one edge
                done_r <= (state_r == DONE);
                if (mismatch_s) begin
                    fail_r <= 1'b1;
                    if (!fail_r) begin
                        fail_add_r <= addr_r;
                        fail_exp_r <= mem_in_r;
                        fail_act_r <= bus.mem_o;
                    end
                    if (err_cnt_r != 7'd127) begin
                        err_cnt_r <= err_cnt_r + 7'd1;
                    end
                end
            end
        end
    end

    assign bus.mem_add  = addr_r;
    assign bus.mem_in   = mem_in_r;
    assign bus.mem_load = mem_load_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.fail     = fail_r;
    assign bus.fail_add = fail_add_r;
    assign bus.fail_exp = fail_exp_r;
    assign bus.fail_act = fail_act_r;
    assign bus.err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_ram64_bist.sv
// Bench for ram64_bist: two engines (run-to-end and stop-on-fail), each with a
// behavioural 64x16 memory whose read path can be forced with stuck-at masks.
module tb_ram64_bist;

    typedef struct packed {
        logic [5:0]  add;
        logic [15:0] din;
        logic        load;
    } op_t;

    typedef struct packed {
        logic [5:0]  add;
        logic [15:0] din;
        logic        load;
        logic        busy;
        logic        done;
        logic        fail;
        logic [5:0]  fadd;
        logic [15:0] fexp;
        logic [15:0] fact;
        logic [6:0]  cnt;
    } obs_t;

    typedef struct {
        logic        fail;
        logic [5:0]  fadd;
        logic [15:0] fexp;
        logic [15:0] fact;
        logic [6:0]  cnt;
        int          edges;
        int          loads;
    } res_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [15:0] m0 [64];
    logic [15:0] m1 [64];
    logic [15:0] and_m [64];
    logic [15:0] or_m [64];

    op_t  op_q [$];
    res_t res_q [$];

    ram64_bist_if b0 ();
    ram64_bist_if b1 ();

    ram64_bist #(.STOP_ON_FAIL(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    ram64_bist #(.STOP_ON_FAIL(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

    assign b0.mem_o = (m0[b0.mem_add] & and_m[b0.mem_add]) | or_m[b0.mem_add];
    assign b1.mem_o = (m1[b1.mem_add] & and_m[b1.mem_add]) | or_m[b1.mem_add];

    obs_t o0;
    obs_t o1;
    assign o0 = {b0.mem_add, b0.mem_in, b0.mem_load, b0.busy, b0.done, b0.fail,
                 b0.fail_add, b0.fail_exp, b0.fail_act, b0.err_cnt};
    assign o1 = {b1.mem_add, b1.mem_in, b1.mem_load, b1.busy, b1.done, b1.fail,
                 b1.fail_add, b1.fail_exp, b1.fail_act, b1.err_cnt};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (b0.mem_load) m0[b0.mem_add] <= b0.mem_in;
    end

    always @(posedge clk) begin
        if (b1.mem_load) m1[b1.mem_add] <= b1.mem_in;
    end

    function automatic obs_t peek(input bit s);
        return s ? o1 : o0;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_start(input bit s, input logic v, input logic [15:0] p);
        if (s) begin
            b1.start = v;
            b1.pat   = p;
        end else begin
            b0.start = v;
            b0.pat   = p;
        end
    endtask

    // Reference March operation list for background p.
    function automatic void build_ops(input logic [15:0] p);
        op_q.delete();
        for (int a = 0; a < 64; a++) op_q.push_back({6'(a), p, 1'b1});
        for (int a = 0; a < 64; a++) begin
            op_q.push_back({6'(a), p, 1'b0});
            op_q.push_back({6'(a), ~p, 1'b1});
        end
        for (int a = 63; a >= 0; a--) begin
            op_q.push_back({6'(a), ~p, 1'b0});
            op_q.push_back({6'(a), p, 1'b1});
        end
        for (int a = 63; a >= 0; a--) op_q.push_back({6'(a), p, 1'b0});
    endfunction

    function automatic void clear_faults();
        for (int a = 0; a < 64; a++) begin
            and_m[a] = 16'hFFFF;
            or_m[a]  = 16'h0000;
        end
    endfunction

    task automatic run_test(input string tag, input bit s, input logic [15:0] p,
                            input int pulse_at, input res_t e);
        obs_t o;
        res_t r;
        op_t  x;
        int   edges;
        int   loads;
        int   op_err;
        res_q.push_back(e);
        build_ops(p);
        @(negedge clk);
        set_start(s, 1'b1, p);
        @(posedge clk);
        @(negedge clk);
        set_start(s, 1'b0, p);
        o = peek(s);
        check({tag, "_clear"}, 128'({o.busy, o.done, o.fail, o.cnt}), 128'({1'b1, 1'b0, 1'b0, 7'd0}));
        edges  = 0;
        loads  = 0;
        op_err = 0;
        while (!o.done && edges < 1000) begin
            if (o.busy) begin
                if (op_q.size() == 0) begin
                    op_err++;
                end else begin
                    x = op_q.pop_front();
                    if (o.add !== x.add || o.din !== x.din || o.load !== x.load) op_err++;
                end
                if (o.load) loads++;
            end
            if (edges == pulse_at) set_start(s, 1'b1, ~p);
            @(posedge clk);
            edges++;
            @(negedge clk);
            set_start(s, 1'b0, p);
            o = peek(s);
        end
        op_q.delete();
        r = res_q.pop_front();
        check({tag, "_edges"}, 128'(edges), 128'(r.edges));
        check({tag, "_loads"}, 128'(loads), 128'(r.loads));
        check({tag, "_ops"}, 128'(op_err), 128'(0));
        check({tag, "_fail"}, 128'(o.fail), 128'(r.fail));
        check({tag, "_fail_add"}, 128'(o.fadd), 128'(r.fadd));
        check({tag, "_fail_exp"}, 128'(o.fexp), 128'(r.fexp));
        check({tag, "_fail_act"}, 128'(o.fact), 128'(r.fact));
        check({tag, "_err_cnt"}, 128'(o.cnt), 128'(r.cnt));
        check({tag, "_done_bus"}, 128'({o.add, o.din, o.load, o.busy}), 128'(0));
    endtask

    initial begin
        obs_t o;
        res_t e;
        int   bad;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        set_start(1'b0, 1'b0, 16'h0000);
        set_start(1'b1, 1'b0, 16'h0000);
        clear_faults();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dut0", 128'(peek(1'b0)), 128'(0));
        check("reset_dut1", 128'(peek(1'b1)), 128'(0));
        reset = 1'b0;

        // fault-free run, background A5A5
        e = '{1'b0, 6'd0, 16'h0000, 16'h0000, 7'd0, 385, 192};
        run_test("clean", 1'b0, 16'hA5A5, -1, e);
        bad = 0;
        for (int a = 0; a < 64; a++) if (m0[a] !== 16'hA5A5) bad++;
        check("clean_mem", 128'(bad), 128'(0));

        // bit 3 of addr 10 stuck at 0, plus a start pulse while busy
        and_m[10] = 16'hFFF7;
        e = '{1'b1, 6'd10, 16'hFFFF, 16'hFFF7, 7'd1, 385, 192};
        run_test("sa0", 1'b0, 16'h0000, 50, e);

        // addr 5 and 20 stuck at 1234; restarted from DONE
        clear_faults();
        and_m[5]  = 16'h0000;
        or_m[5]   = 16'h1234;
        and_m[20] = 16'h0000;
        or_m[20]  = 16'h1234;
        e = '{1'b1, 6'd5, 16'h0000, 16'h1234, 7'd6, 385, 192};
        run_test("stuck2", 1'b0, 16'h0000, -1, e);

        // every address stuck at FFFF: counter saturates
        for (int a = 0; a < 64; a++) or_m[a] = 16'hFFFF;
        e = '{1'b1, 6'd0, 16'h0000, 16'hFFFF, 7'd127, 385, 192};
        run_test("sat", 1'b0, 16'h0000, -1, e);

        // reset in the middle of M1
        clear_faults();
        @(negedge clk);
        set_start(1'b0, 1'b1, 16'h5A5A);
        @(posedge clk);
        @(negedge clk);
        set_start(1'b0, 1'b0, 16'h5A5A);
        repeat (100) @(posedge clk);
        @(negedge clk);
        o = peek(1'b0);
        check("mid_busy", 128'({o.busy, o.load}), 128'({1'b1, 1'b0}));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset", 128'(peek(1'b0)), 128'(0));

        // clean run after the abort
        e = '{1'b0, 6'd0, 16'h0000, 16'h0000, 7'd0, 385, 192};
        run_test("after_rst", 1'b0, 16'h5A5A, -1, e);

        // stop-on-fail engine, same stuck bit as before
        and_m[10] = 16'hFFF7;
        e = '{1'b1, 6'd10, 16'hFFFF, 16'hFFF7, 7'd1, 300, 181};
        run_test("stop", 1'b1, 16'h0000, -1, e);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
